// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: takes one read/write command on a
// valid/ready port, runs one bus cycle with a wait-cycle timeout, and returns
// read data plus error/timeout status on a valid/ready response port.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } state_e;

  // Counter value seen in the last stb cycle the slave is allowed to use.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              rspValid_q, rspValid_d;
  logic              rspErr_q, rspErr_d;
  logic              rspTimeout_q, rspTimeout_d;
  logic [31:0]       rspDat_q, rspDat_d;

  // State and datapath registers; reset drops any bus cycle and pending response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rspValid_q   <= 1'b0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
      rspDat_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rspValid_q   <= rspValid_d;
      rspErr_q     <= rspErr_d;
      rspTimeout_q <= rspTimeout_d;
      rspDat_q     <= rspDat_d;
    end
  end

  // Next-state logic: accept in IDLE, terminate by err > ack > timeout in BUS,
  // hold the response in RSP until the consumer takes it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rspValid_d   = rspValid_q;
    rspErr_d     = rspErr_q;
    rspTimeout_d = rspTimeout_q;
    rspDat_d     = rspDat_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          rspErr_d     = 1'b1;
          rspTimeout_d = 1'b0;
          rspDat_d     = '0;
          rspValid_d   = 1'b1;
          cyc_d        = 1'b0;
          state_d      = RSP;
        end else if (wb_ack_i) begin
          rspErr_d     = 1'b0;
          rspTimeout_d = 1'b0;
          rspDat_d     = we_q ? 32'd0 : wb_dat_i;
          rspValid_d   = 1'b1;
          cyc_d        = 1'b0;
          state_d      = RSP;
        end else if (cnt_q == CntLast) begin
          rspErr_d     = 1'b0;
          rspTimeout_d = 1'b1;
          rspDat_d     = '0;
          rspValid_d   = 1'b1;
          cyc_d        = 1'b0;
          state_d      = RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rspValid_d   = 1'b0;
          rspErr_d     = 1'b0;
          rspTimeout_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign rsp_valid_o   = rspValid_q;
  assign rsp_err_o     = rspErr_q;
  assign rsp_timeout_o = rspTimeout_q;
  assign rsp_dat_o     = rspDat_q;

endmodule
